// File: rtl/jy_irq_timer.sv
`timescale 1ns/1ps
// Mapper IRQ timer: 8-bit prescaler feeding an 8-bit counter, four tick sources
// (CPU M2, filtered PPU A12 rise, PPU read, CPU write), sticky pending flag.
module jy_irq_timer #(
    parameter int A12_FILTER = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        enable,
    input  logic [15:0] prg_ain,
    input  logic        prg_write,
    input  logic [7:0]  prg_din,
    input  logic        ppu_ce,
    input  logic [13:0] chr_ain_o,
    input  logic        chr_read,
    output logic        irq,
    output logic [7:0]  irq_count_o,
    output logic [7:0]  irq_prescaler_o
);

    localparam int LW = (A12_FILTER > 0) ? $clog2(A12_FILTER + 1) : 1;
    localparam logic [LW-1:0] FILT = LW'(A12_FILTER);

    logic [7:0]    r_mode;
    logic [7:0]    r_xor;
    logic [7:0]    r_prescaler;
    logic [7:0]    r_counter;
    logic          r_enabled;
    logic          r_pending;
    logic          r_old_a12;
    logic [LW-1:0] r_low_cnt;

    logic [7:0]    w_mode_next;
    logic [7:0]    w_xor_next;
    logic [7:0]    w_prescaler_next;
    logic [7:0]    w_counter_next;
    logic          w_enabled_next;
    logic          w_pending_next;
    logic          w_old_a12_next;
    logic [LW-1:0] w_low_cnt_next;

    logic          w_reg_sel;
    logic [7:0]    w_wr_idx;
    logic          w_disable;
    logic          w_set_en;
    logic          w_a12;
    logic          w_a12_rise;
    logic          w_tick;
    logic          w_active;
    logic          w_up;
    logic          w_step;
    logic          w_pre_term;
    logic          w_cnt_wrap;
    logic [7:0]    w_pre_step;
    logic [7:0]    w_cnt_step;
    logic          w_unused_bits;

    assign w_unused_bits = ^{chr_ain_o[13], chr_ain_o[11:0], prg_ain[10:3]};

    assign w_reg_sel = ce && prg_write && enable && (prg_ain[15:11] == 5'b11000);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_decode
            assign w_wr_idx[gi] = w_reg_sel && (prg_ain[2:0] == 3'(gi));
        end
    endgenerate

    assign w_disable = (w_wr_idx[0] && !prg_din[0]) || w_wr_idx[2];
    assign w_set_en  = (w_wr_idx[0] &&  prg_din[0]) || w_wr_idx[3];

    // A12 rise only counts after enough low samples to reject short glitches.
    assign w_a12      = chr_ain_o[12];
    assign w_a12_rise = ppu_ce && !r_old_a12 && w_a12 && (r_low_cnt >= FILT);

    always_comb begin
        w_tick = 1'b0;
        case (r_mode[1:0])
            2'b00:   w_tick = ce;
            2'b01:   w_tick = w_a12_rise;
            2'b10:   w_tick = ppu_ce && chr_read;
            default: w_tick = ce && prg_write;
        endcase
    end

    assign w_active = r_enabled && (r_mode[7] ^ r_mode[6]);
    assign w_up     = r_mode[6];
    assign w_step   = w_tick && w_active && enable && !w_disable;

    always_comb begin
        w_pre_term = 1'b0;
        if (r_mode[2]) begin
            w_pre_term = w_up ? (r_prescaler[2:0] == 3'd7) : (r_prescaler[2:0] == 3'd0);
        end else begin
            w_pre_term = w_up ? (r_prescaler == 8'hFF) : (r_prescaler == 8'h00);
        end
    end

    assign w_pre_step = w_up ? (r_prescaler + 8'd1) : (r_prescaler - 8'd1);
    assign w_cnt_step = w_up ? (r_counter + 8'd1) : (r_counter - 8'd1);
    assign w_cnt_wrap = w_up ? (r_counter == 8'hFF) : (r_counter == 8'h00);

    always_comb begin
        w_mode_next      = r_mode;
        w_xor_next       = r_xor;
        w_prescaler_next = r_prescaler;
        w_counter_next   = r_counter;
        w_enabled_next   = r_enabled;
        w_pending_next   = r_pending;
        w_old_a12_next   = r_old_a12;
        w_low_cnt_next   = r_low_cnt;

        if (w_wr_idx[1]) w_mode_next = prg_din;
        if (w_wr_idx[6]) w_xor_next  = prg_din;

        // A register write beats the tick for the register it targets.
        if (w_disable) begin
            w_prescaler_next = 8'h00;
        end else if (w_wr_idx[4]) begin
            w_prescaler_next = prg_din ^ r_xor;
        end else if (w_step) begin
            w_prescaler_next = w_pre_step;
        end

        if (w_wr_idx[5]) begin
            w_counter_next = prg_din ^ r_xor;
        end else if (w_step && w_pre_term) begin
            w_counter_next = w_cnt_step;
        end

        if (w_set_en) w_enabled_next = 1'b1;
        if (w_step && w_pre_term && w_cnt_wrap) w_pending_next = 1'b1;
        if (w_disable) begin
            w_enabled_next = 1'b0;
            w_pending_next = 1'b0;
        end

        if (ppu_ce) begin
            w_old_a12_next = w_a12;
            if (w_a12) begin
                w_low_cnt_next = '0;
            end else if (r_low_cnt < FILT) begin
                w_low_cnt_next = r_low_cnt + 1'b1;
            end
        end

        // Mapper switched off: drop the live IRQ state, keep the programmed values.
        if (!enable) begin
            w_enabled_next = 1'b0;
            w_pending_next = 1'b0;
            w_old_a12_next = 1'b0;
            w_low_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode      <= 8'h00;
            r_xor       <= 8'h00;
            r_prescaler <= 8'h00;
            r_counter   <= 8'h00;
            r_enabled   <= 1'b0;
            r_pending   <= 1'b0;
            r_old_a12   <= 1'b0;
            r_low_cnt   <= '0;
        end else begin
            r_mode      <= w_mode_next;
            r_xor       <= w_xor_next;
            r_prescaler <= w_prescaler_next;
            r_counter   <= w_counter_next;
            r_enabled   <= w_enabled_next;
            r_pending   <= w_pending_next;
            r_old_a12   <= w_old_a12_next;
            r_low_cnt   <= w_low_cnt_next;
        end
    end

    assign irq             = r_pending && r_enabled;
    assign irq_count_o     = r_counter;
    assign irq_prescaler_o = r_prescaler;

endmodule

// File: doc/jy_irq_timer.md
JY_IRQ_TIMER -- requirements
Module: jy_irq_timer

Interface
REQ-001 Parameter: A12_FILTER, default 0, minimum count of consecutive ppu_ce samples with A12 low before an A12 rise is counted.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ce  in  1  M2 CPU-cycle enable.
REQ-005 enable  in  1  mapper enabled.
REQ-006 prg_ain  in  16  CPU address.
REQ-007 prg_write  in  1  CPU write strobe.
REQ-008 prg_din  in  8  CPU write data.
REQ-009 ppu_ce  in  1  PPU cycle enable.
REQ-010 chr_ain_o  in  14  raw PPU address; bit 12 is A12.
REQ-011 chr_read  in  1  PPU read strobe.
REQ-012 irq  out  1  interrupt request, active high.
REQ-013 irq_count_o  out  8  current counter value, for debug.
REQ-014 irq_prescaler_o  out  8  current prescaler value, for debug.

Function
REQ-015 Register write: ce && prg_write && enable && prg_ain[15:11]==5'b11000; register index is prg_ain[2:0].
REQ-016 Index 0: din[0]=1 sets enabled; din[0]=0 performs disable.
- Index 1: mode <= din.
- Index 2: disable.
- Index 3: enabled <= 1.
- Index 4: prescaler <= din ^ xor.
- Index 5: counter <= din ^ xor.
- Index 6: xor <= din.
- Index 7: ignored.
REQ-017 Disable, at the write edge: enabled <= 0, pending <= 0, prescaler <= 0; disable overrides every other update in that cycle.
REQ-018 Tick source, selected by mode[1:0]:
- 00: ce.
- 01: ppu_ce && filtered A12 rise.
- 10: ppu_ce && chr_read.
- 11: ce && prg_write, any address, including the register-write cycle itself.
REQ-019 A12 filter:
- On each ppu_ce, sample A12 into old_a12.
- Low counter increments while A12=0, saturating at A12_FILTER; it clears when A12=1.
- A rise is counted when old_a12=0, A12=1 and low counter >= A12_FILTER.
REQ-020 Counting is active only when enabled=1 and mode[7]!=mode[6]; otherwise ticks are ignored. Direction is up when mode[6]=1, down otherwise.
REQ-021 Each tick steps the 8-bit prescaler by +/-1, modulo 256.
REQ-022 Prescaler terminal value, checked before the step:
- mode[2]=1 (3-bit mode): prescaler[2:0]==7 when counting up, ==0 when counting down.
- mode[2]=0: prescaler==FF when counting up, ==00 when counting down.
REQ-023 At a prescaler terminal value, counter steps +/-1 modulo 256.
REQ-024 If counter was FF (up) or 00 (down) before that step, pending <= 1.
REQ-025 Simultaneous register write and tick: a written prescaler or counter takes the written value; unwritten registers update per the tick.
REQ-026 pending stays set until a disable or reset; a counter wrap while pending is already set has no further effect.
REQ-027 irq = pending && enabled, combinational from registers.
REQ-028 enable=0: synchronously clears enabled, pending and the A12 filter state; prescaler, counter, mode and xor hold.
REQ-029 irq_count_o and irq_prescaler_o mirror the counter and prescaler registers directly.

Reset
REQ-030 reset_n=0 asynchronously clears to 0: mode, xor, prescaler, counter, enabled, pending, old_a12 and low counter; irq=0 during and after reset.
REQ-031 Reset asserted mid-count aborts counting with no residual state; the first tick after release needs a fresh configuration.

Verification
REQ-032 M2 down-count: xor=00, mode=80, prescaler=02, counter=01, write C003, then ce ticks -> counter=00 after 3rd tick; irq rises after 259th tick.
REQ-033 3-bit up-count: mode=44, prescaler=06, counter=FF, enabled -> irq=0 after tick 1; irq=1 after tick 2, counter=00, prescaler=08.
REQ-034 XOR load, disable and re-enable:
- xor=5A, write C005 with 5B -> irq_count_o=01.
- Disable via C000 din=00 while irq=1 -> irq=0 and prescaler=00 next cycle.
- C003 then re-enables with irq remaining 0.
REQ-035 A12 filter: A12_FILTER=3, mode=41, prescaler=FF, counter=FF.
- A12 rise after 2 low ppu_ce samples -> prescaler unchanged.
- Rise after 3 low samples -> prescaler=00, irq=1.
REQ-036 Stall and collision:
- mode=C0 (mode[7]==mode[6]) with 1000 ce ticks -> prescaler and counter unchanged.
- Write C005 coinciding with a source-11 tick -> written value wins.
REQ-037 Async reset mid-count: pull reset_n low between clock edges with irq=1 -> irq=0 immediately, all debug outputs 00.
